poly_add_ctrl: RTL and testbench
================================

POLY_ADD_CTRL -- requirements
Module: poly_add_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, coefficient-memory address width.
REQ-002 SHALL size all data as `DATA_SIZE_ARB bits (shared defines), written W below.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  pulse; job request, sampled only in IDLE.
REQ-007 len  in  ADDR_W+1  coefficient count, 0..2^ADDR_W.
REQ-008 q  in  W  modulus.
REQ-009 base_a, base_b, base_c  in  ADDR_W each  operand A, operand B and result base addresses.
REQ-010 mem_gnt  in  1  read grant from the shared memory arbiter.
REQ-011 rd_en  out  1  read strobe, common to both operand banks.
REQ-012 rd_addr_a, rd_addr_b  out  ADDR_W each  read addresses.
REQ-013 rd_data_a, rd_data_b  in  W each  read data, valid exactly 1 cycle after rd_en.
REQ-014 wr_en  out  1; wr_addr  out  ADDR_W; wr_data  out  W  result write port.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 In IDLE, start=1 with len>0 SHALL latch len, q and all bases, clear index, and enter RUN next cycle.
REQ-019 In IDLE, start=1 with len=0 SHALL enter DONE next cycle without issuing any read or write.
REQ-020 start SHALL be ignored in RUN, DRAIN and DONE; latched parameters SHALL not change mid-job.
REQ-021 In RUN, rd_en SHALL equal mem_gnt; when rd_en=1, rd_addr_x = base_x + idx (mod 2^ADDR_W) and idx increments by 1.
REQ-022 In RUN, when mem_gnt=0, SHALL issue no read and SHALL hold idx.
REQ-023 RUN SHALL go to DRAIN in the cycle after the read with idx = len-1 issues.
REQ-024 Each issued read SHALL produce exactly one write 2 cycles later: data returns at +1, the registered modular add completes at +2, and wr_en=1 at +2.
REQ-025 wr_addr SHALL be base_c + idx of the originating read (mod 2^ADDR_W); writes SHALL occur in issue order.
REQ-026 Arithmetic: s = a + b (W+1 bits); d = s - q (W+2 bits, signed); wr_data = d[W-1:0] if d >= 0, else s[W-1:0].
REQ-027 Operands SHALL be < q; results for operands >= q are unspecified.
REQ-028 A mem_gnt stall SHALL not disturb reads already in flight; their writes still occur on schedule.
REQ-029 DRAIN SHALL go to DONE in the cycle after the final write.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-031 Back-to-back jobs: a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-032 On reset=1 at a clock edge, the block SHALL enter IDLE with idx, latched parameters and pipeline valids cleared.
REQ-033 After reset, busy, done, rd_en and wr_en SHALL be 0; rd_addr_a, rd_addr_b, wr_addr and wr_data SHALL be 0.
REQ-034 Reset mid-job SHALL abort the job, discard in-flight results (no later write), and produce no done pulse.

Structure
REQ-035 The shared defines file SHALL hold `DATA_SIZE_ARB and the state encoding constants.
REQ-036 SHALL contain one sub-module, poly_add_stage: a registered modular add with valid and address sideband, 1-cycle latency.
REQ-037 The FSM, index counter and read-issue logic SHALL stay in poly_add_ctrl.

Verification
REQ-038 Arithmetic, with q=17:
- (10,9) -> 2
- (3,4) -> 7
- (8,9) -> 0
- (16,16) -> 15
REQ-039 Timing: len=4, mem_gnt=1, start accepted at cycle 0 -> rd_en cycles 1-4, wr_en cycles 3-6, done=1 at cycle 7 only.
REQ-040 Stall: same job with mem_gnt=0 in cycles 2-3 -> reads at cycles 1,4,5,6; writes at 3,6,7,8; done at 9.
REQ-041 Wrap: ADDR_W=8, base_a=254, len=4 -> rd_addr_a = 254,255,0,1; wr_addr wraps identically from base_c.
REQ-042 Corner cases:
- len=0 -> done at cycle 1, with no rd_en/wr_en.
- start pulsed in RUN -> ignored.
- reset at cycle 3 of a len=4 job -> no wr_en or done afterwards, all outputs 0.

Source files
------------

// File: rtl/poly_add_ctrl_pkg.sv
// poly_add_ctrl_pkg: shared data width define and FSM state encoding
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif
package poly_add_ctrl_pkg;
  localparam int W = `DATA_SIZE_ARB;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/poly_add_ctrl_if.sv
// poly_add_ctrl_if: job request, memory read/write and status bundle
interface poly_add_ctrl_if import poly_add_ctrl_pkg::*; #(parameter int ADDR_W = 8);
  logic start;
  logic [ADDR_W:0] len;
  logic [W-1:0] q;
  logic [ADDR_W-1:0] base_a, base_b, base_c;
  logic mem_gnt;
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic [W-1:0] rd_data_a, rd_data_b;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic busy, done;
  modport slave (
    input start, len, q, base_a, base_b, base_c, mem_gnt, rd_data_a, rd_data_b,
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, busy, done
  );
  modport master (
    output start, len, q, base_a, base_b, base_c, mem_gnt, rd_data_a, rd_data_b,
    input rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/poly_add_stage.sv
// poly_add_stage: registered modular add with valid and address sideband
module poly_add_stage import poly_add_ctrl_pkg::*; #(parameter int ADDR_W = 8) (
  input  logic clk,
  input  logic reset,
  input  logic in_v,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic out_v,
  output logic [ADDR_W-1:0] out_addr,
  output logic [W-1:0] out_data
);
  logic [W:0] s;
  logic [W-1:0] r;
  assign s = {1'b0, a} + {1'b0, b};
  assign r = W'(s >= {1'b0, q} ? s - {1'b0, q} : s);
  always_ff @(posedge clk) begin
    if (reset) begin
      out_v <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_v <= in_v;
      if (in_v) begin
        out_addr <= in_addr;
        out_data <= r;
      end
    end
  end
endmodule

// File: rtl/poly_add_ctrl.sv
// poly_add_ctrl: streams two coefficient banks through a modular adder into a result bank
module poly_add_ctrl import poly_add_ctrl_pkg::*; #(parameter int ADDR_W = 8) (
  input logic clk,
  input logic reset,
  poly_add_ctrl_if.slave bus
);
  state_t state;
  logic [ADDR_W:0] len_r, idx, idx_nx;
  logic [ADDR_W-1:0] base_a_r, base_b_r, base_c_r, p1_addr;
  logic [W-1:0] q_r;
  logic p1_v;
  assign idx_nx = idx + (ADDR_W+1)'(1);
  assign bus.rd_en = state == RUN && bus.mem_gnt;
  assign bus.rd_addr_a = base_a_r + idx[ADDR_W-1:0];
  assign bus.rd_addr_b = base_b_r + idx[ADDR_W-1:0];
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_r <= '0;
      idx <= '0;
      base_a_r <= '0;
      base_b_r <= '0;
      base_c_r <= '0;
      q_r <= '0;
      p1_v <= 1'b0;
      p1_addr <= '0;
    end else begin
      p1_v <= bus.rd_en;
      p1_addr <= base_c_r + idx[ADDR_W-1:0];
      case (state)
        IDLE:
          if (bus.start && bus.len != '0) begin
            len_r <= bus.len;
            q_r <= bus.q;
            base_a_r <= bus.base_a;
            base_b_r <= bus.base_b;
            base_c_r <= bus.base_c;
            idx <= '0;
            state <= RUN;
          end else if (bus.start) begin
            state <= DONE;
          end
        RUN:
          if (bus.rd_en) begin
            idx <= idx_nx;
            state <= idx_nx == len_r ? DRAIN : RUN;
          end
        DRAIN: state <= bus.wr_en && !p1_v ? DONE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
  poly_add_stage #(.ADDR_W(ADDR_W)) u_stage (
    .clk(clk),
    .reset(reset),
    .in_v(p1_v),
    .in_addr(p1_addr),
    .a(bus.rd_data_a),
    .b(bus.rd_data_b),
    .q(q_r),
    .out_v(bus.wr_en),
    .out_addr(bus.wr_addr),
    .out_data(bus.wr_data)
  );
endmodule

// File: tb/tb_poly_add_ctrl.sv
// tb_poly_add_ctrl: randomized job-level reference checking of poly_add_ctrl
module tb_poly_add_ctrl;
  import poly_add_ctrl_pkg::*;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] mem_a [256];
  logic [W-1:0] mem_b [256];
  int gnt [1024];
  int rd_k [1024];
  int wr_k [1024];
  poly_add_ctrl_if #(.ADDR_W(AW)) bus ();
  poly_add_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, " wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, " rd_addr_a"}, 32'(bus.rd_addr_a), 0);
    chk({tag, " rd_addr_b"}, 32'(bus.rd_addr_b), 0);
    chk({tag, " wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, " wr_data"}, 32'(bus.wr_data), 0);
  endtask
  task automatic run_job(input int n, input int ba, input int bb, input int bc, input int qq,
                         input int gmode, input int rst_at, input bit preload);
    int rd_cyc [$];
    int done_c, last, c, k, ea, eb;
    bit noise, pend;
    logic [AW-1:0] pa, pb;
    if (!preload)
      for (int i = 0; i < 256; i++) begin
        mem_a[i] = W'($urandom_range(qq - 1, 0));
        mem_b[i] = W'($urandom_range(qq - 1, 0));
      end
    for (int i = 0; i < 1024; i++) begin
      gnt[i] = gmode == 0 ? 1 : gmode == 1 ? int'(i != 2 && i != 3) : int'($urandom_range(3, 0) != 0);
      rd_k[i] = -1;
      wr_k[i] = -1;
    end
    c = 1;
    while (rd_cyc.size() < n) begin
      if (gnt[c] != 0) rd_cyc.push_back(c);
      c++;
    end
    for (int i = 0; i < n; i++) begin
      rd_k[rd_cyc[i]] = i;
      wr_k[rd_cyc[i] + 2] = i;
    end
    done_c = n == 0 ? 1 : rd_cyc[n-1] + 3;
    last = rst_at >= 0 ? rst_at + 3 : done_c;
    pend = 1'b0;
    pa = '0;
    pb = '0;
    for (int cy = 0; cy <= last; cy++) begin
      @(negedge clk);
      reset = cy == rst_at;
      noise = cy > 0 && cy <= done_c && (rst_at < 0 || cy < rst_at) && $urandom_range(3, 0) == 0;
      bus.start = cy == 0 || noise;
      bus.len = cy == 0 ? (AW+1)'(n) : (AW+1)'($urandom_range(256, 0));
      bus.q = cy == 0 ? W'(qq) : W'($urandom);
      bus.base_a = cy == 0 ? AW'(ba) : AW'($urandom);
      bus.base_b = cy == 0 ? AW'(bb) : AW'($urandom);
      bus.base_c = cy == 0 ? AW'(bc) : AW'($urandom);
      bus.mem_gnt = gnt[cy] != 0;
      bus.rd_data_a = pend ? mem_a[pa] : W'($urandom);
      bus.rd_data_b = pend ? mem_b[pb] : W'($urandom);
      #1;
      if (rst_at >= 0 && cy > rst_at) begin
        chk_idle_zero($sformatf("abort c%0d", cy));
      end else begin
        chk($sformatf("rd_en c%0d", cy), 32'(bus.rd_en), 32'(rd_k[cy] >= 0));
        chk($sformatf("wr_en c%0d", cy), 32'(bus.wr_en), 32'(wr_k[cy] >= 0));
        chk($sformatf("done c%0d", cy), 32'(bus.done), 32'(cy == done_c));
        chk($sformatf("busy c%0d", cy), 32'(bus.busy), 32'(cy >= 1 && cy <= done_c));
        if (rd_k[cy] >= 0) begin
          chk($sformatf("rd_addr_a c%0d", cy), 32'(bus.rd_addr_a), 32'((ba + rd_k[cy]) % 256));
          chk($sformatf("rd_addr_b c%0d", cy), 32'(bus.rd_addr_b), 32'((bb + rd_k[cy]) % 256));
        end
        if (wr_k[cy] >= 0) begin
          k = wr_k[cy];
          ea = int'(mem_a[(ba + k) % 256]);
          eb = int'(mem_b[(bb + k) % 256]);
          chk($sformatf("wr_addr c%0d", cy), 32'(bus.wr_addr), 32'((bc + k) % 256));
          chk($sformatf("wr_data c%0d", cy), 32'(bus.wr_data), 32'((ea + eb) % qq));
        end
      end
      pend = bus.rd_en;
      pa = bus.rd_addr_a;
      pb = bus.rd_addr_b;
    end
  endtask
  initial begin
    int n, rs;
    bus.start = 1'b0;
    bus.len = '0;
    bus.q = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    bus.base_c = '0;
    bus.mem_gnt = 1'b1;
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_zero("reset");
    run_job(4, 10, 20, 30, 17, 0, -1, 1'b0);
    run_job(4, 10, 20, 30, 17, 1, -1, 1'b0);
    mem_a[40] = 10; mem_a[41] = 3; mem_a[42] = 8; mem_a[43] = 16;
    mem_b[80] = 9;  mem_b[81] = 4; mem_b[82] = 9; mem_b[83] = 16;
    run_job(4, 40, 80, 120, 17, 0, -1, 1'b1);
    run_job(4, 254, 100, 253, 1000, 0, -1, 1'b0);
    run_job(0, 5, 6, 7, 17, 0, -1, 1'b0);
    run_job(4, 10, 20, 30, 17, 0, 3, 1'b0);
    run_job(12, 200, 250, 251, 65535, 2, -1, 1'b0);
    run_job(1, 255, 255, 255, 1, 0, -1, 1'b0);
    run_job(256, 3, 7, 11, 40000, 0, -1, 1'b0);
    for (int j = 0; j < 15; j++) begin
      n = $urandom_range(40, 0);
      rs = $urandom_range(4, 0) == 0 ? int'($urandom_range(n + 4, 1)) : -1;
      run_job(n, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0),
              $urandom_range(65535, 1), 2, rs, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
